// File: rtl/vga3_object.sv
// Scanline object walker: reads object rows, emits clipped, pre-stepped span fragments and writes stepped edges back.
// Latency: 6 cycles per visible object and 1 per skipped object; a fragment is visible 1 cycle after EMIT.
// Backpressure: span_ready low fills the span FIFO; once it is full the walker holds in EMIT.

module vga3_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         head_vld,
    output logic [W-1:0] head_dat
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign do_pop   = pop && head_vld;
    assign do_push  = push_vld && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

module vga3_object #(
    parameter int NUM_OBJ    = 256,
    parameter int FRAC_BITS  = 12,
    parameter int FIFO_DEPTH = 4,
    localparam int XW   = 24 - FRAC_BITS,
    localparam int AW   = $clog2(4 * NUM_OBJ),
    localparam int RA_W = ((AW + 4) > 14) ? (AW + 4) : 14
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start_of_line,
    input  logic [9:0]      scanline_y,
    input  logic            vga_reg_write,
    input  logic [RA_W-1:0] vga_reg_address,
    input  logic [31:0]     vga_reg_wdata,
    input  logic            span_ready,
    output logic            span_valid,
    output logic [4:0]      span_mode,
    output logic [XW-1:0]   span_x1,
    output logic [XW-1:0]   span_x2,
    output logic [23:0]     span_z,
    output logic [23:0]     span_dzdx,
    output logic [23:0]     span_u,
    output logic [23:0]     span_dudx,
    output logic [23:0]     span_v,
    output logic [23:0]     span_dvdx,
    output logic [31:0]     span_src_addr,
    output logic [31:0]     span_src_stride,
    output logic            line_done,
    output logic            line_overrun
);
    localparam int IW = $clog2(NUM_OBJ);
    localparam int SW = 5 + 2 * XW + 6 * 24 + 64;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OBJ - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD0  = 3'd1;
    localparam logic [2:0] RD1  = 3'd2;
    localparam logic [2:0] RD2  = 3'd3;
    localparam logic [2:0] RD3  = 3'd4;
    localparam logic [2:0] WB   = 3'd5;
    localparam logic [2:0] EMIT = 3'd6;

    logic [127:0]  mem [4 * NUM_OBJ];
    logic [127:0]  ram_q;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wa_row;

    logic [2:0]    state, state_nx;
    logic [IW-1:0] index, index_nx, index_inc;
    logic          done_nx, ovr_nx, wb_en, push, span_pop, fifo_full;

    logic [127:0]  row0_q, row1_q, row2_q, wb_row;
    logic [XW-1:0] sx1_r, sx2_r;
    logic [23:0]   z_pre_r, u_pre_r, v_pre_r;
    logic          empty_r;

    logic signed [15:0] line_s;
    logic               obj_active, last_rd0, last_emit;
    logic signed [24:0] xi1_s, xi2_s, clip1_s, clip2_s, sx1_s, sx2_s, d_s;
    logic [23:0]        d24, z_pre, u_pre, v_pre;
    logic [SW-1:0]      fifo_din, fifo_head;
    logic               unused_bits;

    assign wa_row    = vga_reg_address[AW+3:4];
    assign index_inc = index + 1'b1;
    assign span_pop  = span_valid && span_ready;

    // Port A lanes from the copper, port B row-1 write-back and registered read for the walker.
    always_ff @(posedge clock) begin
        if (vga_reg_write) begin
            mem[wa_row][{vga_reg_address[3:2], 5'd0} +: 32] <= vga_reg_wdata;
        end
        if (wb_en) begin
            mem[{index, 2'd1}] <= wb_row;
        end
        ram_q <= mem[rd_addr];
    end

    assign line_s     = $signed({6'd0, scanline_y});
    assign obj_active = ($signed(ram_q[15:0]) <= line_s) && (line_s < $signed(ram_q[31:16]));
    assign last_rd0   = ram_q[79] || (index == LAST_IDX);
    assign last_emit  = row0_q[79] || (index == LAST_IDX);

    // Clipping in a wide signed domain so clip and edge widths never truncate the compare.
    assign xi1_s   = 25'($signed(row1_q[23:FRAC_BITS]));
    assign xi2_s   = 25'($signed(row1_q[47:24+FRAC_BITS]));
    assign clip1_s = 25'($signed(row0_q[43:32]));
    assign clip2_s = 25'($signed(row0_q[59:48]));
    assign sx1_s   = (xi1_s > clip1_s) ? xi1_s : clip1_s;
    assign sx2_s   = (xi2_s < clip2_s) ? xi2_s : clip2_s;
    assign d_s     = sx1_s - xi1_s;
    assign d24     = d_s[23:0];
    assign z_pre   = row1_q[71:48]  + row2_q[55:32]  * d24;
    assign u_pre   = row1_q[95:72]  + row2_q[79:56]  * d24;
    assign v_pre   = row1_q[119:96] + row2_q[103:80] * d24;

    always_comb begin
        state_nx = state;
        index_nx = index;
        rd_addr  = {index, 2'd0};
        done_nx  = 1'b0;
        ovr_nx   = 1'b0;
        wb_en    = 1'b0;
        push     = 1'b0;
        if (start_of_line) begin
            state_nx = RD0;
            index_nx = '0;
            rd_addr  = '0;
            ovr_nx   = (state != IDLE);
        end else begin
            case (state)
                RD0: begin
                    if (obj_active) begin
                        state_nx = RD1;
                        rd_addr  = {index, 2'd1};
                    end else if (last_rd0) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        index_nx = index_inc;
                        rd_addr  = {index_inc, 2'd0};
                    end
                end
                RD1: begin
                    state_nx = RD2;
                    rd_addr  = {index, 2'd2};
                end
                RD2: begin
                    state_nx = RD3;
                    rd_addr  = {index, 2'd3};
                end
                RD3: state_nx = WB;
                WB: begin
                    wb_en    = 1'b1;
                    state_nx = EMIT;
                end
                EMIT: begin
                    if (empty_r || !fifo_full || span_pop) begin
                        push = !empty_r;
                        if (last_emit) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx = RD0;
                            index_nx = index_inc;
                            rd_addr  = {index_inc, 2'd0};
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            index        <= '0;
            line_done    <= 1'b0;
            line_overrun <= 1'b0;
        end else begin
            state        <= state_nx;
            index        <= index_nx;
            line_done    <= done_nx;
            line_overrun <= ovr_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row0_q  <= '0;
            row1_q  <= '0;
            row2_q  <= '0;
            wb_row  <= '0;
            sx1_r   <= '0;
            sx2_r   <= '0;
            z_pre_r <= '0;
            u_pre_r <= '0;
            v_pre_r <= '0;
            empty_r <= 1'b1;
        end else begin
            if (state == RD0) row0_q <= ram_q;
            if (state == RD1) row1_q <= ram_q;
            if (state == RD2) row2_q <= ram_q;
            if (state == RD3) begin
                sx1_r   <= sx1_s[XW-1:0];
                sx2_r   <= sx2_s[XW-1:0];
                z_pre_r <= z_pre;
                u_pre_r <= u_pre;
                v_pre_r <= v_pre;
                empty_r <= (sx1_s >= sx2_s);
                wb_row  <= {row1_q[127:120],
                            row1_q[119:96] + ram_q[119:96],
                            row1_q[95:72]  + ram_q[95:72],
                            row1_q[71:48]  + ram_q[71:48],
                            row1_q[47:24]  + ram_q[47:24],
                            row1_q[23:0]   + ram_q[23:0]};
            end
        end
    end

    assign fifo_din = {row0_q[68:64], sx1_r, sx2_r,
                       z_pre_r, row2_q[55:32], u_pre_r, row2_q[79:56], v_pre_r, row2_q[103:80],
                       row2_q[31:0], row0_q[127:96]};

    vga3_fifo #(.W(SW), .DEPTH(FIFO_DEPTH)) u_span_fifo (
        .clock    (clock),
        .reset    (reset),
        .clear    (start_of_line),
        .push_vld (push),
        .push_dat (fifo_din),
        .pop      (span_pop),
        .full     (fifo_full),
        .head_vld (span_valid),
        .head_dat (fifo_head)
    );

    assign {span_mode, span_x1, span_x2, span_z, span_dzdx, span_u, span_dudx,
            span_v, span_dvdx, span_src_addr, span_src_stride} = fifo_head;

    assign unused_bits = ^{vga_reg_address, row0_q[47:44], row0_q[63:60], row0_q[78:69],
                           row0_q[95:80], row2_q[127:104], sx1_s, sx2_s, d_s};
endmodule

// File: tb/tb_vga3_object.sv
// Directed bench for vga3_object: copper writes objects, walks lines, and a scoreboard checks each popped fragment.
module tb_vga3_object;
    localparam int NUM_OBJ    = 8;
    localparam int FRAC_BITS  = 12;
    localparam int FIFO_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_of_line = 1'b0;
    logic [9:0]  scanline_y = '0;
    logic        vga_reg_write = 1'b0;
    logic [13:0] vga_reg_address = '0;
    logic [31:0] vga_reg_wdata = '0;
    logic        span_ready = 1'b1;
    logic        span_valid, line_done, line_overrun;
    logic [4:0]  span_mode;
    logic [11:0] span_x1, span_x2;
    logic [23:0] span_z, span_dzdx, span_u, span_dudx, span_v, span_dvdx;
    logic [31:0] span_src_addr, span_src_stride;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [4:0]  mode;
        logic [11:0] x1, x2;
        logic [23:0] z, dzdx, u, dudx, v, dvdx;
        logic [31:0] src, stride;
    } span_t;

    typedef struct {
        logic [15:0] ys, ye;
        logic [11:0] c1, c2;
        logic [4:0]  mode;
        logic        last;
        logic [31:0] stride, src;
        logic [23:0] x1, x2, z, u, v, dzdx, dudx, dvdx, dx1dy, dx2dy, dzdy, dudy, dvdy;
    } obj_t;

    span_t exp_q[$];
    span_t got, exp_s;

    vga3_object #(.NUM_OBJ(NUM_OBJ), .FRAC_BITS(FRAC_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock(clock), .reset(reset), .start_of_line(start_of_line), .scanline_y(scanline_y),
        .vga_reg_write(vga_reg_write), .vga_reg_address(vga_reg_address), .vga_reg_wdata(vga_reg_wdata),
        .span_ready(span_ready), .span_valid(span_valid), .span_mode(span_mode),
        .span_x1(span_x1), .span_x2(span_x2), .span_z(span_z), .span_dzdx(span_dzdx),
        .span_u(span_u), .span_dudx(span_dudx), .span_v(span_v), .span_dvdx(span_dvdx),
        .span_src_addr(span_src_addr), .span_src_stride(span_src_stride),
        .line_done(line_done), .line_overrun(line_overrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && span_valid && span_ready) begin
            got = {span_mode, span_x1, span_x2, span_z, span_dzdx, span_u, span_dudx,
                   span_v, span_dvdx, span_src_addr, span_src_stride};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_span got=%h", got);
            end else begin
                exp_s = exp_q.pop_front();
                if (got !== exp_s) begin
                    miscompares++;
                    $display("FAIL span got=%h expected=%h", got, exp_s);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic span_t mk(input logic [4:0] mode, input logic [11:0] x1, input logic [11:0] x2,
                                 input logic [23:0] z, input logic [23:0] dzdx, input logic [23:0] u,
                                 input logic [23:0] dudx, input logic [23:0] v, input logic [23:0] dvdx,
                                 input logic [31:0] src, input logic [31:0] stride);
        return {mode, x1, x2, z, dzdx, u, dudx, v, dvdx, src, stride};
    endfunction

    function automatic obj_t idle_obj();
        obj_t o;
        o = '{default: '0};
        o.ys = 16'd100;
        o.ye = 16'd100;
        return o;
    endfunction

    task automatic write_row(input int row, input logic [127:0] d);
        for (int lane = 0; lane < 4; lane++) begin
            @(posedge clock); #1;
            vga_reg_write   = 1'b1;
            vga_reg_address = 14'(row * 16 + lane * 4);
            vga_reg_wdata   = d[lane*32 +: 32];
        end
        @(posedge clock); #1;
        vga_reg_write = 1'b0;
    endtask

    task automatic write_obj(input int i, input obj_t o);
        logic [127:0] r0;
        r0 = '0;
        r0[15:0] = o.ys;  r0[31:16] = o.ye;  r0[43:32] = o.c1;  r0[59:48] = o.c2;
        r0[68:64] = o.mode;  r0[79] = o.last;  r0[127:96] = o.stride;
        write_row(4*i,   r0);
        write_row(4*i+1, {8'h0, o.v, o.u, o.z, o.x2, o.x1});
        write_row(4*i+2, {24'h0, o.dvdx, o.dudx, o.dzdx, o.src});
        write_row(4*i+3, {8'h0, o.dvdy, o.dudy, o.dzdy, o.dx2dy, o.dx1dy});
    endtask

    task automatic start_line(input logic [9:0] y);
        @(posedge clock); #1;
        scanline_y    = y;
        start_of_line = 1'b1;
        @(posedge clock); #1;
        start_of_line = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!line_done && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clock);
            k++;
        end
        repeat (2) @(posedge clock);
        #1;
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        obj_t o;
        int n;
        logic seen;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_valid", 64'(span_valid), 64'd0);
        chk("reset_done", 64'(line_done), 64'd0);
        chk("reset_overrun", 64'(line_overrun), 64'd0);
        chk("reset_x1", 64'(span_x1), 64'd0);
        chk("reset_z", 64'(span_z), 64'd0);
        chk("reset_src", 64'(span_src_addr), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < NUM_OBJ; i++) write_obj(i, idle_obj());

        // Single visible object, then its stepped edges on the following line.
        o = idle_obj();
        o.ys = 5; o.ye = 7; o.c1 = 0; o.c2 = 640; o.mode = 3; o.last = 1;
        o.stride = 32'h280; o.src = 32'hDEADBEEF;
        o.x1 = 24'h00A000; o.x2 = 24'h032000; o.z = 24'h123456; o.u = 24'h000111; o.v = 24'h000222;
        o.dzdx = 24'h10; o.dudx = 24'h20; o.dvdx = 24'h30;
        o.dx1dy = 24'h001000; o.dx2dy = 24'hFFF000; o.dzdy = 1; o.dudy = 2; o.dvdy = 3;
        write_obj(0, o);
        exp_q.push_back(mk(3, 10, 50, 24'h123456, 24'h10, 24'h111, 24'h20, 24'h222, 24'h30, 32'hDEADBEEF, 32'h280));
        start_line(5);
        wait_done(n);
        chk("done_visible_latency", 64'(n), 64'd7);
        exp_q.push_back(mk(3, 11, 49, 24'h123457, 24'h10, 24'h113, 24'h20, 24'h225, 24'h30, 32'hDEADBEEF, 32'h280));
        start_line(6);
        wait_done(n);
        chk("done_line6", 64'(n), 64'd7);
        start_line(7);
        wait_done(n);
        chk("done_skip_latency", 64'(n), 64'd2);
        drain("drain_single");

        // Left and right clipping with pre-stepped Z/U/V.
        o = idle_obj();
        o.ys = 0; o.ye = 10; o.c1 = 20; o.c2 = 640; o.mode = 1; o.last = 1; o.src = 32'h1000;
        o.x1 = 24'h005000; o.x2 = 24'h2BC000; o.u = 24'h10;
        o.dzdx = 24'h100; o.dudx = 24'h2; o.dvdx = 24'hFFFFFF;
        write_obj(0, o);
        exp_q.push_back(mk(1, 20, 640, 24'h000F00, 24'h100, 24'h2E, 24'h2, 24'hFFFFF1, 24'hFFFFFF, 32'h1000, 32'h0));
        start_line(3);
        wait_done(n);
        chk("done_clip", 64'(n), 64'd7);
        drain("drain_clip");

        // Fully clipped span still steps; skipped object is not written; last stops the walk.
        o = idle_obj();
        o.ys = 0; o.ye = 10; o.c1 = 20; o.c2 = 640; o.mode = 2;
        o.x2 = 24'h00A000; o.dx2dy = 24'h014000; o.dzdx = 24'h1;
        write_obj(0, o);
        o = idle_obj();
        o.ys = 50; o.ye = 60; o.c2 = 640; o.mode = 4; o.src = 32'h11;
        o.x1 = 24'h001000; o.x2 = 24'h002000; o.dx1dy = 24'h001000; o.dx2dy = 24'h001000;
        write_obj(1, o);
        o = idle_obj();
        o.last = 1;
        write_obj(2, o);
        o = idle_obj();
        o.ys = 0; o.ye = 10; o.c2 = 640; o.x2 = 24'h005000;
        write_obj(3, o);
        start_line(3);
        wait_done(n);
        chk("done_last_obj2", 64'(n), 64'd9);
        exp_q.push_back(mk(2, 20, 30, 24'h14, 24'h1, 24'h0, 24'h0, 24'h0, 24'h0, 32'h0, 32'h0));
        start_line(4);
        wait_done(n);
        chk("done_stepped_empty", 64'(n), 64'd9);
        exp_q.push_back(mk(4, 1, 2, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 32'h11, 32'h0));
        start_line(50);
        wait_done(n);
        chk("done_unwritten_skip", 64'(n), 64'd9);
        drain("drain_clipped");

        // Six visible objects against a stalled consumer.
        for (int i = 0; i < 6; i++) begin
            o = idle_obj();
            o.ys = 0; o.ye = 10; o.c2 = 640; o.mode = 5'(i); o.last = (i == 5);
            o.x1 = 24'(i) << 12; o.x2 = 24'(i + 10) << 12; o.src = 32'h100 + 32'(i);
            write_obj(i, o);
        end
        span_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            exp_q.push_back(mk(5'(i), 12'(i), 12'(i + 10), 0, 0, 0, 0, 0, 0, 32'h100 + 32'(i), 0));
        start_line(1);
        seen = 1'b0;
        repeat (60) begin
            @(posedge clock); #1;
            if (line_done) seen = 1'b1;
        end
        chk("stall_no_done", 64'(seen), 64'd0);
        chk("stall_valid", 64'(span_valid), 64'd1);
        chk("stall_head_x1", 64'(span_x1), 64'd0);
        chk("stall_head_src", 64'(span_src_addr), 64'h100);
        span_ready = 1'b1;
        wait_done(n);
        chk("stall_done_seen", 64'(line_done), 64'd1);
        drain("drain_stall");

        // Restart mid-walk: overrun pulse, FIFO flushed, walk restarts at object 0.
        span_ready = 1'b0;
        start_line(1);
        repeat (19) @(posedge clock);
        #1;
        start_line(1);
        chk("overrun_pulse", 64'(line_overrun), 64'd1);
        chk("overrun_flush", 64'(span_valid), 64'd0);
        @(posedge clock); #1;
        chk("overrun_one_cycle", 64'(line_overrun), 64'd0);
        for (int i = 0; i < 6; i++)
            exp_q.push_back(mk(5'(i), 12'(i), 12'(i + 10), 0, 0, 0, 0, 0, 0, 32'h100 + 32'(i), 0));
        span_ready = 1'b1;
        wait_done(n);
        chk("restart_done_seen", 64'(line_done), 64'd1);
        drain("drain_restart");

        // Synchronous reset mid-walk.
        span_ready = 1'b0;
        start_line(1);
        repeat (10) @(posedge clock);
        #1;
        chk("prereset_valid", 64'(span_valid), 64'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midreset_valid", 64'(span_valid), 64'd0);
        chk("midreset_x1", 64'(span_x1), 64'd0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clock); #1;
            if (line_done || span_valid) seen = 1'b1;
        end
        chk("postreset_idle", 64'(seen), 64'd0);
        span_ready = 1'b1;

        // Without last, the walk ends at the final RAM object.
        o = idle_obj();
        o.ys = 0; o.ye = 10; o.c2 = 640; o.mode = 5;
        o.x1 = 24'h005000; o.x2 = 24'h00F000; o.src = 32'h105;
        write_obj(5, o);
        start_line(200);
        wait_done(n);
        chk("done_all_skipped", 64'(n), 64'd9);
        for (int i = 0; i < 6; i++)
            exp_q.push_back(mk(5'(i), 12'(i), 12'(i + 10), 0, 0, 0, 0, 0, 0, 32'h100 + 32'(i), 0));
        start_line(1);
        wait_done(n);
        chk("done_last_index", 64'(n), 64'd39);
        drain("drain_last_index");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
